// File: rtl/code_breaker.sv
// code_breaker: guess-entry and scoring engine for the Mastermind datapath.
// Latches the secret from the code-maker stage, collects four 3-bit digits
// from the breaker player, scores exact then partial matches over six
// cycles (EXACT, 4x PARTIAL, REPORT), counts guesses and flags win/lose.
// Ports:
//   clk, reset (async, active low)
//   started, active_p, secret[11:0]  - code-maker handoff, sampled in IDLE
//   enterA, enterB, SW[2:0]          - digit entry pulses and value
//   new_game                         - leaves DONE
//   breaker, guess_out[11:0], exact[2:0], partial[2:0], fb_valid,
//   guess_cnt[3:0], busy, win, lose  - registered / state-decoded outputs
module code_breaker #(
  parameter int MAX_GUESSES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        started,
  input  logic        active_p,
  input  logic [11:0] secret,
  input  logic        enterA,
  input  logic        enterB,
  input  logic [2:0]  SW,
  input  logic        new_game,
  output logic        breaker,
  output logic [11:0] guess_out,
  output logic [2:0]  exact,
  output logic [2:0]  partial,
  output logic        fb_valid,
  output logic [3:0]  guess_cnt,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    EXACT   = 3'd2,
    PARTIAL = 3'd3,
    REPORT  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  logic [11:0] code_reg;
  logic [1:0]  dig_cnt;
  logic [1:0]  idx;
  logic [3:0]  g_used;
  logic [3:0]  s_used;

  // Digit k sits at [11-3k -: 3]; the first digit entered ends up in k=0.
  logic [3:0][2:0] g_dig, c_dig;
  logic [3:0]      eq;

  for (genvar k = 0; k < 4; k++) begin : g_digit
    assign g_dig[k] = guess_out[11-3*k -: 3];
    assign c_dig[k] = code_reg[11-3*k -: 3];
    assign eq[k]    = (g_dig[k] == c_dig[k]);
  end

  logic [2:0] exact_sum;
  always_comb begin
    exact_sum = '0;
    for (int k = 0; k < 4; k++) exact_sum = exact_sum + {2'b00, eq[k]};
  end

  // Lowest-index unused secret digit equal to guess digit idx. Scanning
  // downward lets the lowest match overwrite any higher one.
  logic       hit;
  logic [1:0] hit_pos;
  always_comb begin
    hit     = 1'b0;
    hit_pos = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (!s_used[j] && (c_dig[j] == g_dig[idx])) begin
        hit     = 1'b1;
        hit_pos = 2'(j);
      end
    end
  end

  // Only the breaker's own enter counts, even if both pulse together.
  logic accept;
  assign accept = breaker ? enterB : enterA;

  assign fb_valid = (state == REPORT);
  assign busy     = (state == EXACT) || (state == PARTIAL) || (state == REPORT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      code_reg  <= '0;
      breaker   <= 1'b0;
      guess_out <= '0;
      exact     <= '0;
      partial   <= '0;
      guess_cnt <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      dig_cnt   <= '0;
      idx       <= '0;
      g_used    <= '0;
      s_used    <= '0;
    end else begin
      case (state)
        IDLE: if (started) begin
          code_reg  <= secret;
          breaker   <= ~active_p;
          guess_out <= '0;
          exact     <= '0;
          partial   <= '0;
          guess_cnt <= '0;
          win       <= 1'b0;
          lose      <= 1'b0;
          dig_cnt   <= '0;
          state     <= ENTRY;
        end
        ENTRY: if (accept) begin
          guess_out <= {guess_out[8:0], SW};
          dig_cnt   <= dig_cnt + 2'd1;   // wraps to 0 on the 4th digit
          if (dig_cnt == 2'd3) state <= EXACT;
        end
        EXACT: begin
          exact   <= exact_sum;
          g_used  <= eq;
          s_used  <= eq;
          partial <= '0;
          idx     <= '0;
          state   <= PARTIAL;
        end
        PARTIAL: begin
          if (!g_used[idx] && hit) begin
            s_used[hit_pos] <= 1'b1;
            partial         <= partial + 3'd1;
          end
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            guess_cnt <= guess_cnt + 4'd1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (exact == 3'd4) begin
            win   <= 1'b1;
            state <= DONE;
          end else if (guess_cnt == 4'(MAX_GUESSES)) begin
            lose  <= 1'b1;
            state <= DONE;
          end else begin
            state <= ENTRY;
          end
        end
        DONE: if (new_game) begin
          // Leaving a finished game clears the scoreboard so the next
          // game starts from a blank display.
          breaker   <= 1'b0;
          guess_out <= '0;
          exact     <= '0;
          partial   <= '0;
          guess_cnt <= '0;
          win       <= 1'b0;
          lose      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_breaker.sv
// Directed bench for code_breaker: win, duplicate scoring, player gating,
// lose path with new_game, and async reset in the middle of PARTIAL.
module tb_code_breaker;

  logic        clk = 1'b0;
  logic        reset;
  logic        started, active_p, enterA, enterB, new_game;
  logic [11:0] secret;
  logic [2:0]  SW;
  logic        breaker, fb_valid, busy, win, lose;
  logic [11:0] guess_out;
  logic [2:0]  exact, partial;
  logic [3:0]  guess_cnt;

  int checks = 0;
  int errors = 0;

  code_breaker #(.MAX_GUESSES(6)) dut (
    .clk(clk), .reset(reset), .started(started), .active_p(active_p),
    .secret(secret), .enterA(enterA), .enterB(enterB), .SW(SW),
    .new_game(new_game), .breaker(breaker), .guess_out(guess_out),
    .exact(exact), .partial(partial), .fb_valid(fb_valid),
    .guess_cnt(guess_cnt), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {5'd0, breaker, guess_out, exact, partial, fb_valid, guess_cnt, busy, win, lose};
  endfunction

  // All tasks are entered and left at a falling edge.
  task automatic start_game(input logic [11:0] sec, input logic ap);
    secret = sec; active_p = ap; started = 1'b1;
    @(negedge clk);
    started = 1'b0;
  endtask

  task automatic enter(input logic a, input logic b, input logic [2:0] v);
    SW = v; enterA = a; enterB = b;
    @(negedge clk);
    enterA = 1'b0; enterB = 1'b0;
  endtask

  task automatic guess4(input logic b, input logic [2:0] d0, d1, d2, d3);
    enter(!b, b, d0);
    enter(!b, b, d1);
    enter(!b, b, d2);
    enter(!b, b, d3);
  endtask

  // Called at the falling edge right after the 4th digit was accepted;
  // fb_valid must appear 5 clocks later. Leaves one edge past REPORT.
  task automatic check_fb(input string tag, input logic [2:0] ex, pa, input logic [3:0] cnt);
    int cyc = 0;
    while (!fb_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 5);
    chk({tag, "_exact"}, exact, ex);
    chk({tag, "_partial"}, partial, pa);
    chk({tag, "_cnt"}, guess_cnt, cnt);
    chk({tag, "_busy"}, busy, 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; started = 0; active_p = 0; enterA = 0; enterB = 0;
    new_game = 0; secret = '0; SW = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", all_outs(), 0);
    reset = 1'b1;
    @(negedge clk);

    // Win on first guess: secret 1,2,3,4, maker A so breaker B.
    start_game(12'h29C, 1'b0);
    chk("t1_breaker", breaker, 1);
    guess4(1'b1, 3'd1, 3'd2, 3'd3, 3'd4);
    check_fb("t1", 3'd4, 3'd0, 4'd1);
    chk("t1_win", win, 1);
    chk("t1_lose", lose, 0);
    chk("t1_idle_busy", busy, 0);
    enter(1'b0, 1'b1, 3'd7);
    chk("t1_done_hold", guess_out, 12'h29C);
    chk("t1_done_cnt", guess_cnt, 1);
    pulse_new_game();
    chk("t1_ng_win", win, 0);
    chk("t1_ng_guess", guess_out, 0);

    // Duplicates: secret 1,1,2,2, maker B so breaker A.
    start_game(12'h252, 1'b1);
    chk("t2_breaker", breaker, 0);
    guess4(1'b0, 3'd2, 3'd2, 3'd1, 3'd1);
    check_fb("t2a", 3'd0, 3'd4, 4'd1);
    chk("t2a_win", win, 0);
    chk("t2a_busy", busy, 0);
    guess4(1'b0, 3'd1, 3'd2, 3'd7, 3'd7);
    check_fb("t2b", 3'd1, 3'd1, 4'd2);
    do_reset();

    // Player gating plus single-credit duplicate: secret 5,0,0,0, breaker B.
    start_game(12'hA00, 1'b0);
    for (int i = 0; i < 4; i++) enter(1'b1, 1'b0, 3'd3);
    chk("t3_a_ignored", guess_out, 0);
    chk("t3_a_busy", busy, 0);
    enter(1'b1, 1'b1, 3'd5);
    enter(1'b0, 1'b1, 3'd5);
    enter(1'b0, 1'b1, 3'd5);
    chk("t3_three", guess_out, 12'h16D);
    chk("t3_three_busy", busy, 0);
    enter(1'b0, 1'b1, 3'd5);
    chk("t3_guess", guess_out, 12'hB6D);
    check_fb("t3", 3'd1, 3'd0, 4'd1);

    // Lose path: secret 0,1,2,3, six guesses of 7,7,7,7.
    do_reset();
    start_game(12'h053, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      guess4(1'b1, 3'd7, 3'd7, 3'd7, 3'd7);
      check_fb($sformatf("t4_g%0d", i), 3'd0, 3'd0, 4'(i));
      if (i < 6) chk($sformatf("t4_g%0d_lose", i), lose, 0);
    end
    chk("t4_lose", lose, 1);
    chk("t4_win", win, 0);
    enter(1'b0, 1'b1, 3'd1);
    chk("t4_done_guess", guess_out, 12'hFFF);
    chk("t4_done_busy", busy, 0);
    chk("t4_done_cnt", guess_cnt, 6);
    pulse_new_game();
    chk("t4_ng_lose", lose, 0);
    chk("t4_ng_cnt", guess_cnt, 0);
    chk("t4_ng_guess", guess_out, 0);

    // Async reset two cycles into PARTIAL.
    start_game(12'h29C, 1'b0);
    guess4(1'b1, 3'd1, 3'd2, 3'd3, 3'd4);
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", busy, 1);
    chk("t5_exact_pre", exact, 4);
    reset = 1'b0;
    #1;
    chk("t5_rst_outs", all_outs(), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_post_outs", all_outs(), 0);
    start_game(12'h053, 1'b1);
    chk("t5_breaker", breaker, 0);
    guess4(1'b0, 3'd0, 3'd1, 3'd2, 3'd3);
    check_fb("t5", 3'd4, 3'd0, 4'd1);
    chk("t5_win", win, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
